seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a board bank of common-anode seven-segment digits. All digits share one cathode bus (CA_to_CG, DP).
- Holds a hex display word in a shadow register and cycles one active-low anode at a time. It decodes the selected nibble to the shared cathode pattern and inserts a blanking gap between digits to suppress ghosting.
- New display words are accepted by a load handshake and committed only at frame boundaries, so the display never tears. Sits between the lab top-level logic and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off (>= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- value  in  4*NUM_DIGITS  hex word; nibble i drives digit i (digit 0 = rightmost, bits 3:0).
- dp_in  in  NUM_DIGITS  decimal-point request per digit (1 = lit).
- digit_en  in  NUM_DIGITS  per-digit enable (0 = digit blanked).
- lz_en  in  1  leading-zero suppression enable.
- load_req  in  1  one-cycle strobe: capture value/dp_in into pending.
- load_ack  out  1  one-cycle pulse when pending is committed to display.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0.
- AN  out  NUM_DIGITS  anodes, active low.
- CA_to_CG  out  7  cathodes CA..CG (bit6 = CA), active low.
- DP  out  1  decimal-point cathode, active low.

Behaviour:
- Reset (synchronous, highest priority), taking effect on the next clk edge:
  - prescaler = 0, digit index = 0, state = BLANK.
  - display word = 0, display dp = 0, pending flag = 0.
  - AN = all 1, CA_to_CG = 7'b1111111, DP = 1, load_ack = 0, frame_tick = 0.
  - Reset asserted mid-slot or mid-handshake discards the pending word and issues no ack.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - At count REFRESH_DIV-1 the slot ends and the index increments modulo NUM_DIGITS.
- Slot FSM, with the count taken before the edge:
  - BLANK to DRIVE when count == BLANK_CYCLES-1.
  - DRIVE to BLANK at slot end.
  - In BLANK: AN all 1, CA_to_CG = 7'b1111111, DP = 1.
  - In DRIVE: AN has a single 0 at bit [index] if the digit is visible, else all 1.
- Visibility: a digit is visible iff digit_en[index] = 1 and it is not suppressed.
- Leading-zero suppression (lz_en = 1):
  - Digit i > 0 is suppressed when display nibbles i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - Suppression uses the committed display word only.
- Decode in DRIVE, for nibble = display[index]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - DP = ~display_dp[index]. An invisible digit drives all cathodes 1.
- Output timing:
  - AN, CA_to_CG and DP are registered and reflect the state/index one cycle after those change.
  - The first lit cycle of a slot is BLANK_CYCLES+1 cycles after slot start.
- Frame tick: frame_tick pulses in the cycle after the edge on which the index wraps NUM_DIGITS-1 to 0.
- Load handshake:
  - load_req = 1 captures value and dp_in into pending and sets the pending flag.
  - A further load_req before commit overwrites pending (last wins); only one ack is issued.
  - Commit happens on the wrap edge: display takes pending, the flag clears, and load_ack pulses together with frame_tick.
  - If load_req and the wrap edge coincide, the new word is captured and committed on that same edge, the flag stays 0, and ack pulses.
  - digit_en, dp_in select and lz_en are used live; only value and dp are shadowed.
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=4 unless noted):
- Reset: hold rst for 3 cycles, then release -> AN=1111, CA_to_CG=1111111, DP=1 during rst. First AN=1110 appears 2 cycles after release and lasts 3 cycles. A gap of all-1 precedes AN=1101, and the slot period is 4 cycles.
- Load/commit: load_req with value=16'h12AF, dp_in=4'b0100 mid-frame -> no change until wrap, then load_ack and frame_tick pulse together. Digits then show F=0111000, A=0001000, 2=0010010 with DP=0, 1=1001111.
- Overwrite and coincidence: pulse 16'h1111 then 16'h2222 in the same frame -> a single ack and 2222 shown. A load_req of 16'h3333 exactly on the wrap edge -> committed immediately with ack in the same pulse.
- Leading zeros: value=16'h0050 committed, lz_en=1 -> digits 3 and 2 AN stay 1111 in their slots; digit 1 shows 5; digit 0 shows 0=0000001. With value=0 only digit 0 lights.
- Masking: digit_en=4'b1010 -> only AN=1101 and AN=0111 are ever driven low, and cathodes are 1111111 in masked slots.
- Reset mid-pending: load_req followed by rst before wrap -> no load_ack ever pulses, and the display word reads 0 after reset.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Shadows the display word, commits new words at frame wrap, blanks between slots.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic                    frame_tick,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              CA_to_CG,
  output logic                    DP
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] display, pending;
  logic [NUM_DIGITS-1:0]   display_dp, pending_dp;
  logic                    pend_flag;

  logic                    slot_end, wrap, visible;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic [NUM_DIGITS-1:0]   an_p0;
  logic [6:0]              ca_p0;
  logic                    dp_p0;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BLANK:   if (cnt == CNT_BLANK_END) state_nxt = DRIVE;
      DRIVE:   if (slot_end)             state_nxt = BLANK;
      default: state_nxt = BLANK;
    endcase
  end

  // zero_from[i] is set when nibbles i..NUM_DIGITS-1 of the committed word are all zero
  always_comb begin
    logic z;
    z = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z & (display[4*i +: 4] == 4'h0);
      zero_from[i] = z;
    end
  end

  always_comb begin
    nib     = display[{idx, 2'b00} +: 4];
    visible = digit_en[idx] && !(lz_en && (idx != '0) && zero_from[idx]);
    an_p0   = '1;
    ca_p0   = 7'b1111111;
    dp_p0   = 1'b1;
    if (state == DRIVE && visible) begin
      an_p0[idx] = 1'b0;
      ca_p0      = seg7(nib);
      dp_p0      = ~display_dp[idx];
    end
  end

  // Registered stage: counters, shadow/commit and pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      display    <= '0;
      display_dp <= '0;
      pending    <= '0;
      pending_dp <= '0;
      pend_flag  <= 1'b0;
      AN         <= '1;
      CA_to_CG   <= 7'b1111111;
      DP         <= 1'b1;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A request landing on the wrap edge bypasses pending and commits directly
      if (wrap) begin
        if (load_req) begin
          display    <= value;
          display_dp <= dp_in;
        end else if (pend_flag) begin
          display    <= pending;
          display_dp <= pending_dp;
        end
        pend_flag <= 1'b0;
      end else if (load_req) begin
        pending    <= value;
        pending_dp <= dp_in;
        pend_flag  <= 1'b1;
      end
      load_ack   <= wrap && (load_req || pend_flag);
      frame_tick <= wrap;
      AN         <= an_p0;
      CA_to_CG   <= ca_p0;
      DP         <= dp_p0;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: slot/frame-position reference model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BL = 1;

  logic          clk = 0;
  logic          rst;
  logic [15:0]   value;
  logic [3:0]    dp_in, digit_en;
  logic          lz_en, load_req;
  logic          load_ack, frame_tick;
  logic [3:0]    AN;
  logic [6:0]    CA_to_CG;
  logic          DP;

  seven_seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_en(lz_en), .load_req(load_req), .load_ack(load_ack), .frame_tick(frame_tick),
    .AN(AN), .CA_to_CG(CA_to_CG), .DP(DP)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ack_count = 0;
  logic [3:0] an_seen = 4'h0;
  logic [6:0] seg_tab [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outputs after edge n depend on slot position (n mod RD) and digit (n / RD)
  int          n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  bit          m_pf;

  always @(posedge clk) begin : model
    logic [3:0] e_an;
    logic [6:0] e_ca;
    logic       e_dp, e_ack, e_tick;
    int         s, d;
    bit         wr, vis;
    e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1; e_ack = 1'b0; e_tick = 1'b0;
    if (rst) begin
      n = 0; m_disp = 16'h0; m_ddp = 4'h0; m_pf = 0;
    end else begin
      s   = n % RD;
      d   = (n / RD) % ND;
      wr  = (s == RD - 1) && (d == ND - 1);
      vis = digit_en[d] && !(lz_en && d > 0 && ((m_disp >> (4 * d)) == 16'h0));
      if (s >= BL && vis) begin
        e_an = ~(4'b0001 << d);
        e_ca = seg_tab[m_disp[4*d +: 4]];
        e_dp = ~m_ddp[d];
      end
      e_tick = wr;
      e_ack  = wr && (load_req || m_pf);
      if (wr) begin
        if (load_req) begin m_disp = value; m_ddp = dp_in; end
        else if (m_pf) begin m_disp = m_pend; m_ddp = m_pdp; end
        m_pf = 0;
      end else if (load_req) begin
        m_pend = value; m_pdp = dp_in; m_pf = 1;
      end
      n++;
    end
    #1;
    check("AN", AN, e_an);
    check("CA_to_CG", CA_to_CG, e_ca);
    check("DP", DP, e_dp);
    check("load_ack", load_ack, e_ack);
    check("frame_tick", frame_tick, e_tick);
    if (load_ack === 1'b1) ack_count++;
    an_seen = an_seen | ~AN;
  end

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_in = dp; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1;
    end
    check({name, "_tick_seen"}, found, 1);
  endtask

  task automatic wait_ack(input string name);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) found = 1;
    end
    check({name, "_ack_seen"}, found, 1);
    check({name, "_ack_with_tick"}, frame_tick, 1);
  endtask

  task automatic expect_digit(input string name, input logic [3:0] an_pat,
                              input logic [6:0] ca, input logic dp);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (AN === an_pat) found = 1;
    end
    check({name, "_AN_seen"}, found, 1);
    check({name, "_CA"}, CA_to_CG, ca);
    check({name, "_DP"}, DP, dp);
  endtask

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst = 1; value = 16'h0; dp_in = 4'h0; digit_en = 4'hF; lz_en = 0; load_req = 0;

    // Reset and first slot timing
    repeat (3) @(negedge clk);
    check("rst_AN", AN, 4'hF);
    check("rst_CA", CA_to_CG, 7'h7F);
    check("rst_DP", DP, 1);
    check("rst_ack", load_ack, 0);
    rst = 0;
    @(negedge clk); check("rel1_AN", AN, 4'hF);
    @(negedge clk); check("rel2_AN", AN, 4'hE);
    check("rel2_CA", CA_to_CG, 7'b0000001);
    @(negedge clk); check("rel3_AN", AN, 4'hE);
    @(negedge clk); check("rel4_AN", AN, 4'hE);
    @(negedge clk); check("gap_AN", AN, 4'hF);
    @(negedge clk); check("dig1_AN", AN, 4'hD);

    // Mid-frame load, commit at wrap
    wait_tick("load");
    repeat (5) @(negedge clk);
    pulse_load(16'h12AF, 4'b0100);
    wait_ack("load");
    expect_digit("l_d0", 4'hE, 7'b0111000, 1);
    expect_digit("l_d1", 4'hD, 7'b0001000, 1);
    expect_digit("l_d2", 4'hB, 7'b0010010, 0);
    expect_digit("l_d3", 4'h7, 7'b1001111, 1);

    // Overwrite within one frame yields a single ack
    begin
      int a0;
      wait_tick("ovw");
      a0 = ack_count;
      repeat (2) @(negedge clk);
      pulse_load(16'h1111, 4'h0);
      repeat (3) @(negedge clk);
      pulse_load(16'h2222, 4'h0);
      wait_tick("ovw2");
      repeat (20) @(negedge clk);
      check("ovw_single_ack", ack_count - a0, 1);
      expect_digit("ovw_d0", 4'hE, 7'b0010010, 1);
    end

    // Request coinciding with the wrap edge
    wait_tick("coin");
    repeat (15) @(negedge clk);
    value = 16'h3333; load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("coin_ack", load_ack, 1);
    check("coin_tick", frame_tick, 1);
    expect_digit("coin_d0", 4'hE, 7'b0000110, 1);

    // Leading-zero suppression
    lz_en = 1;
    pulse_load(16'h0050, 4'h0);
    wait_ack("lz");
    an_seen = 4'h0;
    repeat (16) @(negedge clk);
    check("lz_0050_seen", an_seen, 4'b0011);
    expect_digit("lz_d1", 4'hD, 7'b0100100, 1);
    expect_digit("lz_d0", 4'hE, 7'b0000001, 1);
    pulse_load(16'h0000, 4'h0);
    wait_ack("lz0");
    an_seen = 4'h0;
    repeat (16) @(negedge clk);
    check("lz_0000_seen", an_seen, 4'b0001);

    // Digit masking
    lz_en = 0;
    digit_en = 4'b1010;
    @(negedge clk);
    an_seen = 4'h0;
    repeat (32) @(negedge clk);
    check("mask_seen", an_seen, 4'b1010);
    digit_en = 4'hF;

    // Reset with a pending word discards it
    begin
      int a0;
      pulse_load(16'h5555, 4'h0);
      wait_ack("pre");
      a0 = ack_count;
      repeat (2) @(negedge clk);
      pulse_load(16'h9876, 4'hF);
      repeat (3) @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (40) @(negedge clk);
      check("rstpend_no_ack", ack_count - a0, 0);
      expect_digit("rstpend_d0", 4'hE, 7'b0000001, 1);
      expect_digit("rstpend_d3", 4'h7, 7'b0000001, 1);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
